// File: rtl/mhp_tx_scheduler.sv
// Round-robin scheduler that shares one frame assembler among NUM_REQ requesters.
// Latches the winner's fields, starts the assembler, waits for done (with watchdog), then gaps.
module mhp_tx_scheduler #(
  parameter int          NUM_REQ    = 4,
  parameter logic [15:0] SRC_ADDR   = 16'h0001,
  parameter int          GAP_CYCLES = 2,
  parameter int          TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*16-1:0]   req_dst,
  input  logic [NUM_REQ-1:0]      req_dir,
  input  logic [NUM_REQ*7-1:0]    req_type,
  input  logic [NUM_REQ*16-1:0]   req_size,
  input  logic [NUM_REQ*336-1:0]  req_payload,
  input  logic [NUM_REQ*6-1:0]    req_payload_size,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      req_err,
  output logic [15:0]             asm_dst,
  output logic [15:0]             asm_src,
  output logic [15:0]             asm_size,
  output logic                    asm_dir,
  output logic [6:0]              asm_type,
  output logic [335:0]            asm_payload,
  output logic [5:0]              asm_payload_size,
  output logic                    asm_start,
  input  logic                    asm_done,
  output logic                    busy,
  output logic [2:0]              grant_idx,
  output logic [7:0]              timeout_cnt
);

  localparam int GAP_EFF = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
  localparam int TO_EFF  = (TIMEOUT < 2) ? 2 : TIMEOUT;
  localparam int GAP_W   = $clog2(GAP_EFF + 1);
  localparam int WD_W    = $clog2(TO_EFF + 1);
  localparam logic [5:0] MAX_PAYLOAD = 6'd42;
  localparam logic [NUM_REQ-1:0] ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t state, state_next;

  logic [2:0]       last;
  logic [2:0]       sel;
  logic [2:0]       cand;
  logic             sel_valid;
  logic             load;
  logic             to_inc;
  logic [5:0]       sel_psize;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
  logic [WD_W-1:0]  wd_cnt, wd_cnt_next;
  logic [NUM_REQ-1:0] ack_next, err_next;

  logic [7:0]   req_arr;
  logic [15:0]  dst_arr   [8];
  logic         dir_arr   [8];
  logic [6:0]   type_arr  [8];
  logic [15:0]  size_arr  [8];
  logic [335:0] pay_arr   [8];
  logic [5:0]   psize_arr [8];

  // Pad every requester field out to 8 slots so a 3-bit index selects cleanly.
  for (genvar i = 0; i < 8; i++) begin : g_fields
    if (i < NUM_REQ) begin : g_used
      assign req_arr[i]   = req[i];
      assign dst_arr[i]   = req_dst[16*i +: 16];
      assign dir_arr[i]   = req_dir[i];
      assign type_arr[i]  = req_type[7*i +: 7];
      assign size_arr[i]  = req_size[16*i +: 16];
      assign pay_arr[i]   = req_payload[336*i +: 336];
      assign psize_arr[i] = req_payload_size[6*i +: 6];
    end else begin : g_unused
      assign req_arr[i]   = 1'b0;
      assign dst_arr[i]   = '0;
      assign dir_arr[i]   = 1'b0;
      assign type_arr[i]  = '0;
      assign size_arr[i]  = '0;
      assign pay_arr[i]   = '0;
      assign psize_arr[i] = '0;
    end
  end

  // Search starts just after the last winner so every pending requester gets a turn.
  always_comb begin
    sel       = last;
    sel_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 3'((int'(last) + k) % NUM_REQ);
      if (!sel_valid && req_arr[cand]) begin
        sel       = cand;
        sel_valid = 1'b1;
      end
    end
  end

  assign sel_psize = (psize_arr[sel] > MAX_PAYLOAD) ? MAX_PAYLOAD : psize_arr[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A done arriving on the timeout cycle takes priority over the abort.
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    to_inc       = 1'b0;
    gap_cnt_next = gap_cnt;
    wd_cnt_next  = wd_cnt;
    ack_next     = '0;
    err_next     = '0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        wd_cnt_next = '0;
        state_next  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (asm_done) begin
          ack_next     = ONE_HOT << grant_idx;
          gap_cnt_next = GAP_W'(GAP_EFF);
          state_next   = GAP;
        end else if (wd_cnt == WD_W'(TO_EFF - 2)) begin
          err_next     = ONE_HOT << grant_idx;
          to_inc       = 1'b1;
          gap_cnt_next = GAP_W'(GAP_EFF);
          state_next   = GAP;
        end else begin
          wd_cnt_next = wd_cnt + 1'b1;
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt - 1'b1;
        if (gap_cnt <= GAP_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last             <= 3'(NUM_REQ - 1);
      grant_idx        <= '0;
      gap_cnt          <= '0;
      wd_cnt           <= '0;
      req_ack          <= '0;
      req_err          <= '0;
      timeout_cnt      <= '0;
      asm_dst          <= '0;
      asm_size         <= '0;
      asm_dir          <= 1'b0;
      asm_type         <= '0;
      asm_payload      <= '0;
      asm_payload_size <= '0;
    end else begin
      gap_cnt <= gap_cnt_next;
      wd_cnt  <= wd_cnt_next;
      req_ack <= ack_next;
      req_err <= err_next;
      if (to_inc && timeout_cnt != 8'hFF) begin
        timeout_cnt <= timeout_cnt + 8'd1;
      end
      if (load) begin
        last             <= sel;
        grant_idx        <= sel;
        asm_dst          <= dst_arr[sel];
        asm_size         <= size_arr[sel];
        asm_dir          <= dir_arr[sel];
        asm_type         <= type_arr[sel];
        asm_payload      <= pay_arr[sel];
        asm_payload_size <= sel_psize;
      end
    end
  end

  assign asm_src   = SRC_ADDR;
  assign asm_start = (state == START);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mhp_tx_scheduler.sv
// Self-checking bench for mhp_tx_scheduler: vector table plus hand sequences,
// with a start/ack scoreboard driven by a simple assembler responder.
module tb_mhp_tx_scheduler;

  localparam int          NUM_REQ    = 4;
  localparam logic [15:0] SRC_ADDR   = 16'h0001;
  localparam int          GAP_CYCLES = 2;
  localparam int          TIMEOUT    = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*16-1:0]  req_dst;
  logic [NUM_REQ-1:0]     req_dir;
  logic [NUM_REQ*7-1:0]   req_type;
  logic [NUM_REQ*16-1:0]  req_size;
  logic [NUM_REQ*336-1:0] req_payload;
  logic [NUM_REQ*6-1:0]   req_payload_size;
  logic [NUM_REQ-1:0]     req_ack;
  logic [NUM_REQ-1:0]     req_err;
  logic [15:0]            asm_dst;
  logic [15:0]            asm_src;
  logic [15:0]            asm_size;
  logic                   asm_dir;
  logic [6:0]             asm_type;
  logic [335:0]           asm_payload;
  logic [5:0]             asm_payload_size;
  logic                   asm_start;
  logic                   asm_done;
  logic                   busy;
  logic [2:0]             grant_idx;
  logic [7:0]             timeout_cnt;

  mhp_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .SRC_ADDR(SRC_ADDR), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_dst(req_dst), .req_dir(req_dir),
    .req_type(req_type), .req_size(req_size), .req_payload(req_payload),
    .req_payload_size(req_payload_size), .req_ack(req_ack), .req_err(req_err),
    .asm_dst(asm_dst), .asm_src(asm_src), .asm_size(asm_size), .asm_dir(asm_dir),
    .asm_type(asm_type), .asm_payload(asm_payload), .asm_payload_size(asm_payload_size),
    .asm_start(asm_start), .asm_done(asm_done), .busy(busy), .grant_idx(grant_idx),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] dst;
    logic [6:0]  ftype;
    logic        dir;
    logic [15:0] size;
    logic [5:0]  psize;
    logic [7:0]  pbyte;
    logic [2:0]  exp_grant;
    logic [5:0]  exp_psize;
  } vec_t;

  typedef struct {
    logic [2:0]   grant;
    logic [15:0]  dst;
    logic [6:0]   ftype;
    logic         dir;
    logic [15:0]  size;
    logic [5:0]   psize;
    logic [335:0] payload;
    logic         is_err;
  } frame_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     done_delay = -1;
  int     cyc = 0;
  int     last_start_cyc = 0;
  bit     have_start = 1'b0;
  bit     have_cur = 1'b0;
  int     n_acks = 0;
  frame_t cur;
  frame_t exp_q[$];
  vec_t   vecs[6];

  task automatic check_output(input string name, input logic [335:0] actual, input logic [335:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic set_fields(input vec_t v);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_dst[16*i +: 16]         = v.dst ^ 16'(i);
      req_type[7*i +: 7]          = v.ftype ^ 7'(i);
      req_dir[i]                  = v.dir ^ 1'(i);
      req_size[16*i +: 16]        = v.size + 16'(i);
      req_payload[336*i +: 336]   = {42{v.pbyte ^ 8'(i)}};
      req_payload_size[6*i +: 6]  = v.psize;
    end
  endtask

  function automatic frame_t expect_frame(input vec_t v, input logic [2:0] g, input logic is_err);
    frame_t f;
    f.grant   = g;
    f.dst     = v.dst ^ 16'(g);
    f.ftype   = v.ftype ^ 7'(g);
    f.dir     = v.dir ^ g[0];
    f.size    = v.size + 16'(g);
    f.psize   = v.exp_psize;
    f.payload = {42{v.pbyte ^ 8'(g)}};
    f.is_err  = is_err;
    return f;
  endfunction

  task automatic wait_start(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!asm_start && n < max_cyc);
    check_output("start_seen", 336'(asm_start), 336'(1));
  endtask

  task automatic wait_outcome(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((req_ack | req_err) == '0 && n < max_cyc);
    check_output("outcome_seen", 336'((req_ack | req_err) != '0), 336'(1));
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_output("idle_reached", 336'(busy), 336'(0));
  endtask

  // One table vector: request, drop req after grant, disturb inputs, confirm latched fields hold.
  task automatic apply_stimulus(input vec_t v);
    frame_t f;
    int     n;
    set_fields(v);
    f = expect_frame(v, v.exp_grant, 1'b0);
    exp_q.push_back(f);
    req = v.mask;
    wait_start(10, n);
    req = '0;
    req_payload      = ~req_payload;
    req_dst          = ~req_dst;
    req_payload_size = ~req_payload_size;
    wait_outcome(20, n);
    check_output("payload_hold", asm_payload, f.payload);
    check_output("dst_hold", 336'(asm_dst), 336'(f.dst));
    check_output("psize_hold", 336'(asm_payload_size), 336'(f.psize));
    wait_idle(10);
  endtask

  // Assembler model: raise done for one edge done_delay cycles after start; never if negative.
  initial begin
    asm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (asm_start && done_delay >= 0) begin
        repeat (done_delay) @(negedge clk);
        asm_done = 1'b1;
        @(negedge clk);
        asm_done = 1'b0;
      end
    end
  end

  // Scoreboard: pop an expected frame on each start, match the following ack/err pulse to it.
  initial begin
    logic [3:0] exp_ack, exp_err;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        have_cur = 1'b0;
      end else begin
        if (asm_start) begin
          check_output("start_expected", 336'(exp_q.size() != 0), 336'(1));
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            check_output("grant_idx", 336'(grant_idx), 336'(cur.grant));
            check_output("asm_dst", 336'(asm_dst), 336'(cur.dst));
            check_output("asm_src", 336'(asm_src), 336'(SRC_ADDR));
            check_output("asm_type", 336'(asm_type), 336'(cur.ftype));
            check_output("asm_dir", 336'(asm_dir), 336'(cur.dir));
            check_output("asm_size", 336'(asm_size), 336'(cur.size));
            check_output("asm_payload_size", 336'(asm_payload_size), 336'(cur.psize));
            check_output("asm_payload", asm_payload, cur.payload);
          end
          if (have_start) begin
            n_checks++;
            if (cyc - last_start_cyc < GAP_CYCLES + 2) begin
              n_fail++;
              $display("[TB] FAIL start_spacing: got %0d cycles required at least %0d", cyc - last_start_cyc, GAP_CYCLES + 2);
            end
          end
          have_start = 1'b1;
          last_start_cyc = cyc;
        end
        if ((req_ack | req_err) != '0) begin
          check_output("outcome_expected", 336'(have_cur), 336'(1));
          check_output("single_ack_err", 336'($countones(req_ack | req_err)), 336'(1));
          if (have_cur) begin
            exp_ack = cur.is_err ? 4'b0000 : (4'b0001 << cur.grant);
            exp_err = cur.is_err ? (4'b0001 << cur.grant) : 4'b0000;
            check_output("req_ack", 336'(req_ack), 336'(exp_ack));
            check_output("req_err", 336'(req_err), 336'(exp_err));
            if (req_ack != '0) n_acks++;
            have_cur = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got stuck required completion");
    $fatal(1, "[TB] stuck");
  end

  initial begin
    vec_t   base;
    frame_t f;
    int     n;
    int     acks_before;
    logic [2:0] held_order [6];

    vecs[0] = '{4'b1111, 16'hA000, 7'h11, 1'b0, 16'h0100, 6'd10, 8'h5A, 3'd1, 6'd10};
    vecs[1] = '{4'b0101, 16'hB010, 7'h22, 1'b1, 16'h0200, 6'd50, 8'hC3, 3'd2, 6'd42};
    vecs[2] = '{4'b0011, 16'hC020, 7'h33, 1'b0, 16'h0300, 6'd42, 8'h0F, 3'd0, 6'd42};
    vecs[3] = '{4'b0100, 16'hD030, 7'h44, 1'b1, 16'h0400, 6'd43, 8'hF0, 3'd2, 6'd42};
    vecs[4] = '{4'b0110, 16'hE040, 7'h55, 1'b0, 16'h0500, 6'd0,  8'h99, 3'd1, 6'd0};
    vecs[5] = '{4'b1000, 16'hF050, 7'h66, 1'b1, 16'h0600, 6'd63, 8'h3C, 3'd3, 6'd42};
    held_order = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};

    rst = 1'b1;
    req = '0;
    req_dst = '0; req_dir = '0; req_type = '0; req_size = '0;
    req_payload = '0; req_payload_size = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset values");
    check_output("rst_busy", 336'(busy), 336'(0));
    check_output("rst_start", 336'(asm_start), 336'(0));
    check_output("rst_ack", 336'(req_ack), 336'(0));
    check_output("rst_err", 336'(req_err), 336'(0));
    check_output("rst_grant", 336'(grant_idx), 336'(0));
    check_output("rst_tocnt", 336'(timeout_cnt), 336'(0));
    check_output("rst_dst", 336'(asm_dst), 336'(0));
    check_output("rst_src", 336'(asm_src), 336'(SRC_ADDR));

    $display("[TB] single frame, done after 8 cycles");
    done_delay = 8;
    base = '{4'b0001, 16'h1234, 7'h05, 1'b1, 16'h0040, 6'd5, 8'hA5, 3'd0, 6'd5};
    set_fields(base);
    exp_q.push_back(expect_frame(base, 3'd0, 1'b0));
    req = 4'b0001;
    wait_start(10, n);
    check_output("start_latency", 336'(n), 336'(1));
    req = '0;
    @(negedge clk);
    check_output("start_one_cycle", 336'(asm_start), 336'(0));
    wait_outcome(40, n);
    check_output("ack_latency", 336'(n + 1), 336'(9));
    @(negedge clk);
    check_output("busy_in_gap", 336'(busy), 336'(1));
    @(negedge clk);
    check_output("busy_drop", 336'(busy), 336'(0));

    $display("[TB] vector table");
    done_delay = 3;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i]);
    end

    $display("[TB] held requests 1011");
    done_delay = 1;
    base = '{4'b1011, 16'h7000, 7'h01, 1'b0, 16'h0010, 6'd8, 8'h11, 3'd0, 6'd8};
    set_fields(base);
    for (int k = 0; k < 6; k++) exp_q.push_back(expect_frame(base, held_order[k], 1'b0));
    acks_before = n_acks;
    req = 4'b1011;
    for (int k = 0; k < 6; k++) wait_start(20, n);
    req = '0;
    wait_outcome(20, n);
    wait_idle(10);
    check_output("held_ack_count", 336'(n_acks - acks_before), 336'(6));

    $display("[TB] watchdog timeout then next requester");
    done_delay = -1;
    base = '{4'b0011, 16'h8000, 7'h02, 1'b1, 16'h0020, 6'd3, 8'h22, 3'd0, 6'd3};
    set_fields(base);
    exp_q.push_back(expect_frame(base, 3'd0, 1'b1));
    exp_q.push_back(expect_frame(base, 3'd1, 1'b0));
    req = 4'b0011;
    wait_start(10, n);
    @(negedge clk);
    done_delay = 2;
    req = 4'b0010;
    for (int k = 2; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == TIMEOUT - 1) check_output("err_not_early", 336'(req_err), 336'(0));
      if (k == TIMEOUT) begin
        check_output("err_timing", 336'(req_err), 336'(4'b0001));
        check_output("tocnt_one", 336'(timeout_cnt), 336'(1));
      end
    end
    wait_start(10, n);
    req = '0;
    wait_outcome(20, n);
    wait_idle(10);

    $display("[TB] done on the timeout cycle");
    done_delay = TIMEOUT - 1;
    base = '{4'b0001, 16'h9000, 7'h03, 1'b0, 16'h0030, 6'd7, 8'h33, 3'd0, 6'd7};
    set_fields(base);
    exp_q.push_back(expect_frame(base, 3'd0, 1'b0));
    req = 4'b0001;
    wait_start(10, n);
    req = '0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == TIMEOUT - 1) check_output("ack_not_early", 336'(req_ack), 336'(0));
      if (k == TIMEOUT) begin
        check_output("coincide_ack", 336'(req_ack), 336'(4'b0001));
        check_output("coincide_err", 336'(req_err), 336'(0));
        check_output("coincide_tocnt", 336'(timeout_cnt), 336'(1));
      end
    end
    wait_idle(10);

    $display("[TB] reset during WAIT_DONE");
    done_delay = -1;
    base = '{4'b0101, 16'h6000, 7'h04, 1'b1, 16'h0050, 6'd9, 8'h44, 3'd0, 6'd9};
    set_fields(base);
    exp_q.push_back(expect_frame(base, 3'd2, 1'b0));
    req = 4'b0101;
    wait_start(10, n);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_ack", 336'(req_ack), 336'(0));
    check_output("mid_rst_err", 336'(req_err), 336'(0));
    check_output("mid_rst_busy", 336'(busy), 336'(0));
    check_output("mid_rst_start", 336'(asm_start), 336'(0));
    check_output("mid_rst_grant", 336'(grant_idx), 336'(0));
    check_output("mid_rst_dst", 336'(asm_dst), 336'(0));
    check_output("mid_rst_psize", 336'(asm_payload_size), 336'(0));
    check_output("mid_rst_payload", asm_payload, 336'(0));
    check_output("mid_rst_tocnt", 336'(timeout_cnt), 336'(0));
    check_output("mid_rst_src", 336'(asm_src), 336'(SRC_ADDR));
    done_delay = 2;
    exp_q.push_back(expect_frame(base, 3'd0, 1'b0));
    exp_q.push_back(expect_frame(base, 3'd2, 1'b0));
    rst = 1'b0;
    wait_start(10, n);
    check_output("regrant_latency", 336'(n), 336'(1));
    wait_start(20, n);
    req = '0;
    wait_outcome(20, n);
    wait_idle(10);

    repeat (5) @(negedge clk);
    check_output("queue_drained", 336'(exp_q.size()), 336'(0));
    check_output("no_open_frame", 336'(have_cur), 336'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
